// File: rtl/dmem_arbiter.sv
// Two-master arbiter sharing one data_memory port: core load/store (m0) and loader/DMA (m1).
// Build with DMEM_ARB_RR_EN defined for round-robin; otherwise m0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DATA_WIDTH-1:0] m0_addr,
  input  logic [2:0]            m0_rw_type,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DATA_WIDTH-1:0] m1_addr,
  input  logic [2:0]            m1_rw_type,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  W_en,
  output logic                  R_en,
  output logic [DATA_WIDTH-1:0] addr,
  output logic [2:0]            RW_type,
  output logic [DATA_WIDTH-1:0] WD,
  input  logic [DATA_WIDTH-1:0] RD
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  pick1_c;

  // Winner when arbitrating in IDLE: 1 selects master 1.
`ifdef DMEM_ARB_RR_EN
  assign pick1_c = m1_req & (~m0_req | ~last_gnt_q);
`else
  assign pick1_c = m1_req & ~m0_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Every grant lasts exactly one cycle, then the arbiter re-evaluates from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = pick1_c ? ST_GNT1 : ST_GNT0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port and acks decode straight from state, so reset kills an access at once.
  always_comb begin
    W_en    = 1'b0;
    R_en    = 1'b0;
    addr    = '0;
    RW_type = 3'b000;
    WD      = '0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    case (state_q)
      ST_GNT0: begin
        addr    = m0_addr;
        RW_type = m0_rw_type;
        WD      = m0_wdata;
        W_en    = m0_req & m0_we;
        R_en    = m0_req & ~m0_we;
        m0_ack  = m0_req;
      end
      ST_GNT1: begin
        addr    = m1_addr;
        RW_type = m1_rw_type;
        WD      = m1_wdata;
        W_en    = m1_req & m1_we;
        R_en    = m1_req & ~m1_we;
        m1_ack  = m1_req;
      end
      default: ;
    endcase
  end

  // Read capture and completed-grant history.
  always_comb begin
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    last_gnt_d = last_gnt_q;
    if (state_q == ST_GNT0 && R_en) begin
      m0_rdata_d = RD;
    end
    if (state_q == ST_GNT1 && R_en) begin
      m1_rdata_d = RD;
    end
    if (m0_ack) begin
      last_gnt_d = 1'b0;
    end else if (m1_ack) begin
      last_gnt_d = 1'b1;
    end
  end

  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

  a_one_hot_ack: assert property (@(posedge clk) disable iff (!rst_n) !(m0_ack && m1_ack));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural word-addressed memory.
module tb_dmem_arbiter;

  localparam int unsigned DW = 64;

  logic          clk, rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [DW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]    m0_rw_type, m1_rw_type;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          W_en, R_en;
  logic [DW-1:0] addr, WD, RD;
  logic [2:0]    RW_type;

  dmem_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_rw_type(m0_rw_type),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_rw_type(m1_rw_type),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .W_en(W_en), .R_en(R_en), .addr(addr), .RW_type(RW_type), .WD(WD), .RD(RD)
  );

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [2:0]    rwt;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } sb_t;

  sb_t           q0[$], q1[$];
  logic [DW-1:0] mem     [0:63];
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] exp_rd0, exp_rd1;
  int            total, bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign RD = R_en ? mem[addr[8:3]] : '0;
  always @(posedge clk) if (W_en) mem[addr[8:3]] <= WD;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle monitor: held rdata, enables only with an ack, ack payload vs scoreboard.
  always @(negedge clk) begin
    sb_t it;
    chk("m0_rdata", m0_rdata, exp_rd0);
    chk("m1_rdata", m1_rdata, exp_rd1);
    if (m0_ack && m1_ack) chk("dual_ack", 64'd1, 64'd0);
    if (m0_ack) begin
      if (q0.size() == 0) chk("sb0_empty", 64'd1, 64'd0);
      else begin
        it = q0.pop_front();
        chk("m0_wen", 64'(W_en), 64'(it.we));
        chk("m0_ren", 64'(R_en), 64'(!it.we));
        chk("m0_addr", addr, it.addr);
        chk("m0_rwt", 64'(RW_type), 64'(it.rwt));
        if (it.we) chk("m0_wd", WD, it.wdata);
        else exp_rd0 = it.rdata;
      end
    end
    if (m1_ack) begin
      if (q1.size() == 0) chk("sb1_empty", 64'd1, 64'd0);
      else begin
        it = q1.pop_front();
        chk("m1_wen", 64'(W_en), 64'(it.we));
        chk("m1_ren", 64'(R_en), 64'(!it.we));
        chk("m1_addr", addr, it.addr);
        chk("m1_rwt", 64'(RW_type), 64'(it.rwt));
        if (it.we) chk("m1_wd", WD, it.wdata);
        else exp_rd1 = it.rdata;
      end
    end
    if (!m0_ack && !m1_ack) begin
      chk("idle_wen", 64'(W_en), 64'd0);
      chk("idle_ren", 64'(R_en), 64'd0);
    end
  end

  function automatic sb_t mk(input logic we, input logic [DW-1:0] a, input logic [2:0] rwt,
                             input logic [DW-1:0] wd);
    sb_t it;
    it.we    = we;
    it.addr  = a;
    it.rwt   = rwt;
    it.wdata = wd;
    it.rdata = we ? '0 : ref_mem[a[8:3]];
    return it;
  endfunction

  task automatic wait_ack(input bit m, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m ? m1_ack : m0_ack) && n < 20);
    if (!(m ? m1_ack : m0_ack)) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_access(input bit m, input logic we, input logic [DW-1:0] a,
                           input logic [2:0] rwt, input logic [DW-1:0] wd);
    sb_t it;
    int  n;
    it = mk(we, a, rwt, wd);
    if (we) ref_mem[a[8:3]] = wd;
    @(posedge clk); #1;
    if (!m) begin
      q0.push_back(it);
      m0_we = we; m0_addr = a; m0_rw_type = rwt; m0_wdata = wd; m0_req = 1'b1;
    end else begin
      q1.push_back(it);
      m1_we = we; m1_addr = a; m1_rw_type = rwt; m1_wdata = wd; m1_req = 1'b1;
    end
    wait_ack(m, n);
    chk("latency", 64'(n), 64'd2);
    @(posedge clk); #1;
    if (!m) m0_req = 1'b0;
    else    m1_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n   = 1'b0;
    exp_rd0 = '0;
    exp_rd1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int  n;
    bit  e0, e1;
    total = 0; bad = 0;
    exp_rd0 = '0; exp_rd1 = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = {32'hA5A50000 | 32'(i), 32'h0F0F0000 | 32'(i)};
      ref_mem[i] = mem[i];
    end
    mem[2] = 64'h1122334455667788;
    ref_mem[2] = 64'h1122334455667788;

    // Reset with a live request: everything must stay quiet.
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 64'h55; m0_rw_type = 3'b111; m0_wdata = 64'h77;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 64'h66; m1_rw_type = 3'b101; m1_wdata = 64'h99;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", 64'(m0_ack), 64'd0);
    chk("rst_ack1", 64'(m1_ack), 64'd0);
    chk("rst_addr", addr, 64'd0);
    chk("rst_wd", WD, 64'd0);
    chk("rst_rwt", 64'(RW_type), 64'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    #1 rst_n = 1'b1;

    do_access(1'b0, 1'b0, 64'h10, 3'b011, 64'h0);
    do_access(1'b1, 1'b1, 64'h20, 3'b010, 64'hDEADBEEF);
    do_access(1'b0, 1'b0, 64'h20, 3'b011, 64'h0);
    do_access(1'b1, 1'b0, 64'h08, 3'b011, 64'h0);

    // m1 drops its request while granted: access cancelled, FSM returns to IDLE.
    @(posedge clk); #1;
    m1_we = 1'b0; m1_addr = 64'h18; m1_rw_type = 3'b011; m1_req = 1'b1;
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    chk("drop_ack1", 64'(m1_ack), 64'd0);
    chk("drop_ren", 64'(R_en), 64'd0);
    chk("drop_wen", 64'(W_en), 64'd0);
    do_access(1'b1, 1'b0, 64'h18, 3'b011, 64'h0);

    // Back-to-back m0 reads; monitor checks the old value holds through the second grant.
    do_access(1'b0, 1'b0, 64'h00, 3'b011, 64'h0);
    do_access(1'b0, 1'b0, 64'h08, 3'b011, 64'h0);

    // Reset in the middle of a granted m0 write.
    @(posedge clk); #1;
    q0.push_back(mk(1'b1, 64'h30, 3'b011, 64'hBAD0BAD0BAD0BAD0));
    m0_we = 1'b1; m0_addr = 64'h30; m0_rw_type = 3'b011; m0_wdata = 64'hBAD0BAD0BAD0BAD0;
    m0_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_wen_pre", 64'(W_en), 64'd1);
    #2;
    rst_n = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
    #1;
    chk("rstw_wen", 64'(W_en), 64'd0);
    chk("rstw_ack0", 64'(m0_ack), 64'd0);
    m0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_wen", 64'(W_en), 64'd0);
    chk("post_ren", 64'(R_en), 64'd0);
    chk("post_addr", addr, 64'd0);
    chk("post_wd", WD, 64'd0);
    chk("post_rwt", 64'(RW_type), 64'd0);

    // First contended grant after reset goes to m0.
    @(posedge clk); #1;
    q0.push_back(mk(1'b0, 64'h00, 3'b011, 64'h0));
    q1.push_back(mk(1'b0, 64'h28, 3'b011, 64'h0));
    m0_we = 1'b0; m0_addr = 64'h00; m0_rw_type = 3'b011;
    m1_we = 1'b0; m1_addr = 64'h28; m1_rw_type = 3'b011;
    m0_req = 1'b1; m1_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m0_ack && !m1_ack && n < 20);
    chk("first_gnt_m0", 64'(m0_ack), 64'd1);
    @(posedge clk); #1 m0_req = 1'b0;
    wait_ack(1'b1, n);
    @(posedge clk); #1 m1_req = 1'b0;

    // Target word of the aborted write is unchanged.
    do_access(1'b0, 1'b0, 64'h30, 3'b011, 64'h0);

    // Continuous contention for 8 cycles starting from a fresh reset.
    do_reset();
    @(posedge clk); #1;
`ifdef DMEM_ARB_RR_EN
    for (int k = 0; k < 2; k++) begin
      q0.push_back(mk(1'b0, 64'h00, 3'b011, 64'h0));
      q1.push_back(mk(1'b0, 64'h08, 3'b011, 64'h0));
    end
`else
    for (int k = 0; k < 4; k++) q0.push_back(mk(1'b0, 64'h00, 3'b011, 64'h0));
`endif
    m0_we = 1'b0; m0_addr = 64'h00; m0_rw_type = 3'b011;
    m1_we = 1'b0; m1_addr = 64'h08; m1_rw_type = 3'b011;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      e0 = (c == 1) || (c == 5);
      e1 = (c == 3) || (c == 7);
`else
      e0 = (c % 2) == 1;
      e1 = 1'b0;
`endif
      chk($sformatf("cont_ack0_c%0d", c), 64'(m0_ack), 64'(e0));
      chk($sformatf("cont_ack1_c%0d", c), 64'(m1_ack), 64'(e1));
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);

    chk("q0_left", 64'(q0.size()), 64'd0);
    chk("q1_left", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data_memory port between the core load/store path (master 0) and a loader/DMA path (master 1). It sits between the riscv core and data_memory, sequences each access through a small FSM, returns read data in a per-master register, and signals completion with a one-cycle acknowledge.

## Interface

Parameters:
- DATA_WIDTH, 64, width of addresses and data on both masters and on the memory side

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- m0_req  input  1  master 0 request; held high with fields stable until m0_ack
- m0_we  input  1  master 0: 1 = write, 0 = read
- m0_addr  input  DATA_WIDTH  master 0 byte address
- m0_rw_type  input  3  master 0 access size/sign code, passed to memory unchanged
- m0_wdata  input  DATA_WIDTH  master 0 write data
- m0_ack  output  1  master 0 access completes this cycle
- m0_rdata  output  DATA_WIDTH  master 0 registered read data
- m1_req, m1_we, m1_addr, m1_rw_type, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1
- W_en  output  1  memory write enable
- R_en  output  1  memory read enable
- addr  output  DATA_WIDTH  memory address
- RW_type  output  3  memory access type
- WD  output  DATA_WIDTH  memory write data
- RD  input  DATA_WIDTH  memory read data, combinational from addr/R_en

## Operation

- FSM states: IDLE, GNT0, GNT1.
- IDLE: memory outputs all zero. If any req is high, pick the winner (see Configuration) and move to GNT0/GNT1 on the next edge. If no req, stay in IDLE.
- GNTx: memory port driven from master x fields; W_en = mx_req & mx_we; R_en = mx_req & ~mx_we; mx_ack = mx_req. The state always returns to IDLE at the next edge.
- Read capture: at the edge ending GNTx, if R_en is high, RD is loaded into mx_rdata. mx_rdata holds its value until that master's next completed read. Writes never change either rdata register.
- Loser request stays pending. It is arbitrated in the next IDLE cycle.
- If a request drops while in GNTx, that cycle is cancelled: no enables, no ack, no rdata update, and the FSM returns to IDLE.
- The non-granted master's ack is always 0. Both acks are never high together.
- last_gnt register holds the index of the most recent master whose access completed, that is, an ack cycle.

## Timing

- Request seen high in IDLE at cycle N: GNTx and ack at cycle N+1, memory write committed at the end of N+1, m*_rdata valid from N+2.
- Peak throughput: one access per 2 cycles. A continuously requesting master completes every other cycle.
- Reset (async, any state): state = IDLE, last_gnt = 1, m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0, and W_en, R_en, addr, RW_type, WD = 0. Because the enables decode from state, a reset during GNTx aborts the access immediately with no partial write.
- All memory-side outputs and acks are combinational from state and master inputs. There is no registered output skew.

## Configuration

- DMEM_ARB_RR_EN defined: round-robin. In IDLE with both requests high, the master != last_gnt wins. With a single request, that master wins.
- DMEM_ARB_RR_EN undefined: fixed priority. m0 always wins when both request. last_gnt is still maintained but unused.

## Test plan

- Reset then m0 read, addr=0x10, memory preloaded 0x1122334455667788 → m0_ack at N+1, R_en=1, addr=0x10; m0_rdata=0x1122334455667788 from N+2; m1_rdata stays 0.
- m1 write, addr=0x20, wdata=0xDEADBEEF, rw_type=3'b010 → W_en=1 for exactly one cycle with WD=0xDEADBEEF, RW_type=010; a subsequent m0 read of 0x20 returns it.
- Both requests high continuously for 8 cycles with DMEM_ARB_RR_EN → acks alternate m0,m1,m0,m1 at cycles 1,3,5,7. Without the macro → m0 acked at 1,3,5,7 and m1 never acked.
- m1 drops req during GNT1 → W_en=R_en=0, m1_ack=0, m1_rdata unchanged, FSM back in IDLE next cycle.
- Assert rst_n low mid-GNT0 write → W_en falls immediately and target memory word is unchanged; after release all outputs are 0 and the first contended grant goes to m0.
- Back-to-back m0 reads of 0x0 then 0x8 → m0_rdata holds the first value until the edge ending the second GNT0, then updates.
